seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller that shares one `hex_7seg` decoder between up to N_DIGITS digits of a common-anode seven-segment display. Each refresh slot selects one digit, drives its nibble and decimal point to the decoder, and pulls its anode low. A short blanking guard between slots prevents ghosting. New display contents are loaded through a shadow register and committed only at a frame boundary, so the display never tears.

## Interface
- N_DIGITS, 8, number of digits scanned; 2..8.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; ≥1.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  scanning enabled; low forces blank and holds the scan.
- load  in  1  one-cycle pulse that captures data_in, dp_in and mask_in into the shadow register.
- data_in  in  4*N_DIGITS  nibble per digit; digit k = data_in[4k+3:4k].
- dp_in  in  N_DIGITS  decimal point per digit.
- mask_in  in  N_DIGITS  digit enable per digit; 0 keeps that digit dark.
- load_ack  out  1  one-cycle pulse when the shadow is committed to the active register.
- pending  out  1  shadow holds uncommitted data.
- hex_out  out  4  nibble to the decoder input.
- dp_out  out  1  decimal point to the decoder; passed through unchanged.
- an  out  N_DIGITS  anode selects, active-low.
- frame_tick  out  1  one-cycle pulse at each frame end.

## Operation
- State machine: BLANK → DRIVE → BLANK.
  - A slot counter cnt runs 0..REFRESH_DIV-1.
  - BLANK covers cnt 0..BLANK_CYCLES-1; all anodes are high.
  - DRIVE covers cnt BLANK_CYCLES..REFRESH_DIV-1.
- Slot end: cnt = REFRESH_DIV-1 in DRIVE.
  - cnt returns to 0 and the state returns to BLANK.
  - idx increments, and wraps N_DIGITS-1 → 0.
- At the wrap:
  - frame_tick pulses.
  - If pending = 1, shadow → active, load_ack pulses, and pending clears. load_ack and frame_tick are high in the same cycle.
- hex_out and dp_out update on BLANK entry from the active register at the new idx. They are held for the whole slot.
- In DRIVE, an[idx] = 0 only if active_mask[idx] = 1. All other anodes are 1.
- A masked digit still consumes its slot, so brightness stays uniform.
- Load behaviour:
  - load = 1 captures the inputs into the shadow and sets pending.
  - A load while pending overwrites the shadow; the last load wins.
  - A load in the same cycle as a commit: the previous shadow is committed and load_ack pulses. The new data is captured and pending stays 1.
- enable = 0:
  - an is all ones, the state is BLANK, cnt = 0 and idx = 0.
  - Loads are still captured into the shadow.
  - Commits occur only at frame wraps, so pending data waits until enable returns.
  - On enable rising, scanning restarts at digit 0, BLANK, cnt 0.
- Reset values (rst_n low, any time including mid-slot):
  - an all ones; hex_out 0; dp_out 0; load_ack 0; pending 0; frame_tick 0.
  - state BLANK, cnt 0, idx 0.
  - Active and shadow data 0; active and shadow mask 0.
  - Result: display dark until the first commit.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Slot = REFRESH_DIV cycles; frame = N_DIGITS·REFRESH_DIV cycles.
- an for digit k goes low BLANK_CYCLES cycles after that slot's BLANK entry. It stays low for REFRESH_DIV-BLANK_CYCLES cycles.
- hex_out is stable ≥ BLANK_CYCLES cycles before its anode asserts.
- load → pending high on the next edge.
- load → load_ack latency ≤ one frame plus 1 cycle.
- frame_tick asserts in the cycle after the last DRIVE cycle of digit N_DIGITS-1 (first BLANK cycle of digit 0).
- First anode after reset release with enable high: cycle BLANK_CYCLES. Requires a committed, non-zero mask.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset then enable=1, no load → an=4'b1111 for 64 cycles; frame_tick every 32 cycles; load_ack never asserts.
- load with data_in=16'h4321, mask_in=4'hF, dp_in=4'b0100 → load_ack at the first frame wrap. Next frame:
  - Digit 0: hex_out 1, an 4'b1110 on cycles 2–7.
  - Digit 1: hex_out 2. Digit 2: hex_out 3 with dp_out=1. Digit 3: hex_out 4.
  - an high in all BLANK cycles.
- Two loads mid-frame (16'h1111, then 16'h2222) → one load_ack only; next frame displays 2,2,2,2.
- mask_in=4'b0101 → digits 1 and 3 keep an high for their full slots; slot timing unchanged.
- Load coincident with the frame-wrap cycle → old shadow is committed; pending stays 1; the new data is committed at the next wrap with a second load_ack.
- rst_n low mid-DRIVE, and separately enable low mid-frame → an goes to all ones immediately.
  - After reset release: the previous active data is lost (dark display).
  - After enable returns: scanning restarts at digit 0 with the retained active data.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bus bundle between a display-content producer and the seg_scan_ctrl scan engine.
// The master loads digits and watches the handshake; the slave drives the display pins.
interface seg_scan_if #(
  parameter int N_DIGITS = 8
);
  logic                    enable;
  logic                    load;
  logic [4*N_DIGITS-1:0]   data_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     mask_in;
  logic                    load_ack;
  logic                    pending;
  logic [3:0]              hex_out;
  logic                    dp_out;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_tick;

  modport master (
    output enable, load, data_in, dp_in, mask_in,
    input  load_ack, pending, hex_out, dp_out, an, frame_tick
  );

  modport slave (
    input  enable, load, data_in, dp_in, mask_in,
    output load_ack, pending, hex_out, dp_out, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with blanking guard per slot
// and a shadow register that is committed only at frame wrap so the display never tears.
module seg_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_next_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      idx_next_s;
  logic                  slot_end_s;
  logic                  wrap_s;
  logic                  commit_s;

  logic [4*N_DIGITS-1:0] active_data_r;
  logic [N_DIGITS-1:0]   active_dp_r;
  logic [N_DIGITS-1:0]   active_mask_r;
  logic [4*N_DIGITS-1:0] shadow_data_r;
  logic [N_DIGITS-1:0]   shadow_dp_r;
  logic [N_DIGITS-1:0]   shadow_mask_r;
  logic                  pending_r;

  logic [4*N_DIGITS-1:0] active_data_next_s;
  logic [N_DIGITS-1:0]   active_dp_next_s;
  logic [N_DIGITS-1:0]   active_mask_next_s;
  logic [4*N_DIGITS-1:0] shadow_data_next_s;
  logic [N_DIGITS-1:0]   shadow_dp_next_s;
  logic [N_DIGITS-1:0]   shadow_mask_next_s;
  logic                  pending_next_s;

  logic [N_DIGITS-1:0]   an_r;
  logic [N_DIGITS-1:0]   an_next_s;
  logic [3:0]            hex_r;
  logic [3:0]            hex_next_s;
  logic                  dp_r;
  logic                  dp_next_s;
  logic                  load_ack_r;
  logic                  frame_tick_r;

  // Slot sequencing: BLANK guard, then DRIVE until the slot counter runs out.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    idx_next_s   = idx_r;
    slot_end_s   = 1'b0;
    if (!bus.enable) begin
      state_next_s = ST_BLANK;
      cnt_next_s   = '0;
      idx_next_s   = '0;
    end else begin
      case (state_r)
        ST_BLANK: begin
          cnt_next_s = cnt_r + CNT_W'(1);
          if (cnt_r == BLANK_END) begin
            state_next_s = ST_DRIVE;
          end else begin
            state_next_s = ST_BLANK;
          end
        end
        ST_DRIVE: begin
          if (cnt_r == CNT_LAST) begin
            state_next_s = ST_BLANK;
            cnt_next_s   = '0;
            slot_end_s   = 1'b1;
            if (idx_r == IDX_LAST) begin
              idx_next_s = '0;
            end else begin
              idx_next_s = idx_r + IDX_W'(1);
            end
          end else begin
            state_next_s = ST_DRIVE;
            cnt_next_s   = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_next_s = ST_BLANK;
          cnt_next_s   = '0;
          idx_next_s   = '0;
        end
      endcase
    end
  end

  assign wrap_s   = slot_end_s && (idx_r == IDX_LAST);
  assign commit_s = wrap_s && pending_r;

  // Shadow capture and frame-boundary commit; a coincident load lands after the commit.
  always_comb begin
    active_data_next_s = active_data_r;
    active_dp_next_s   = active_dp_r;
    active_mask_next_s = active_mask_r;
    shadow_data_next_s = shadow_data_r;
    shadow_dp_next_s   = shadow_dp_r;
    shadow_mask_next_s = shadow_mask_r;
    pending_next_s     = pending_r;
    if (commit_s) begin
      active_data_next_s = shadow_data_r;
      active_dp_next_s   = shadow_dp_r;
      active_mask_next_s = shadow_mask_r;
      pending_next_s     = 1'b0;
    end else begin
      pending_next_s     = pending_r;
    end
    if (bus.load) begin
      shadow_data_next_s = bus.data_in;
      shadow_dp_next_s   = bus.dp_in;
      shadow_mask_next_s = bus.mask_in;
      pending_next_s     = 1'b1;
    end else begin
      shadow_data_next_s = shadow_data_r;
    end
  end

  // Display outputs are computed from next-cycle state so the registered pins track the FSM exactly.
  always_comb begin
    an_next_s  = '1;
    hex_next_s = hex_r;
    dp_next_s  = dp_r;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_next_s == IDX_W'(k)) begin
        if ((state_next_s == ST_BLANK) && (cnt_next_s == '0)) begin
          hex_next_s = active_data_next_s[4*k +: 4];
          dp_next_s  = active_dp_next_s[k];
        end else begin
          hex_next_s = hex_r;
          dp_next_s  = dp_r;
        end
        if ((state_next_s == ST_DRIVE) && active_mask_next_s[k]) begin
          an_next_s[k] = 1'b0;
        end else begin
          an_next_s[k] = 1'b1;
        end
      end else begin
        an_next_s[k] = 1'b1;
      end
    end
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Active and shadow display contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_data_r <= '0;
      active_dp_r   <= '0;
      active_mask_r <= '0;
      shadow_data_r <= '0;
      shadow_dp_r   <= '0;
      shadow_mask_r <= '0;
      pending_r     <= 1'b0;
    end else begin
      active_data_r <= active_data_next_s;
      active_dp_r   <= active_dp_next_s;
      active_mask_r <= active_mask_next_s;
      shadow_data_r <= shadow_data_next_s;
      shadow_dp_r   <= shadow_dp_next_s;
      shadow_mask_r <= shadow_mask_next_s;
      pending_r     <= pending_next_s;
    end
  end

  // Registered display pins and handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r         <= '1;
      hex_r        <= 4'h0;
      dp_r         <= 1'b0;
      load_ack_r   <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      an_r         <= an_next_s;
      hex_r        <= hex_next_s;
      dp_r         <= dp_next_s;
      load_ack_r   <= commit_s;
      frame_tick_r <= wrap_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.hex_out    = hex_r;
  assign bus.dp_out     = dp_r;
  assign bus.load_ack   = load_ack_r;
  assign bus.frame_tick = frame_tick_r;
  assign bus.pending    = pending_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Outputs are sampled on the falling edge; inputs change right after each sample.
module tb_seg_scan_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seg_scan_if #(.N_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .N_DIGITS    (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic [15:0] exp_hex;
    logic [3:0]  exp_dp;
    logic [15:0] exp_an;
  } vec_t;

  vec_t vecs [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] m);
    bus.data_in = d;
    bus.dp_in   = dp;
    bus.mask_in = m;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (bus.load_ack !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack_seen"}, {31'd0, bus.load_ack}, 32'd1);
  endtask

  // Checks one full 32-cycle frame starting at the current sample (frame cycle 0).
  task automatic check_frame(input string tag, input logic [15:0] ehex, input logic [3:0] edp,
                             input logic [15:0] ean, input logic ft0, input logic ack0);
    int d;
    int cn;
    logic [3:0] ea;
    for (int c = 0; c < 32; c++) begin
      d  = c / 8;
      cn = c % 8;
      ea = (cn >= 2) ? ean[4*d +: 4] : 4'hF;
      chk($sformatf("%s_an_c%0d", tag, c), {28'd0, bus.an}, {28'd0, ea});
      chk($sformatf("%s_hex_c%0d", tag, c), {28'd0, bus.hex_out}, {28'd0, ehex[4*d +: 4]});
      chk($sformatf("%s_dp_c%0d", tag, c), {31'd0, bus.dp_out}, {31'd0, edp[d]});
      chk($sformatf("%s_ft_c%0d", tag, c), {31'd0, bus.frame_tick},
          (c == 0) ? {31'd0, ft0} : 32'd0);
      chk($sformatf("%s_ack_c%0d", tag, c), {31'd0, bus.load_ack},
          (c == 0) ? {31'd0, ack0} : 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{data: 16'h4321, dp: 4'b0100, mask: 4'hF,
                exp_hex: 16'h4321, exp_dp: 4'b0100, exp_an: 16'h7BDE};
    vecs[1] = '{data: 16'h8765, dp: 4'b1001, mask: 4'b0101,
                exp_hex: 16'h8765, exp_dp: 4'b1001, exp_an: 16'hFBFE};
    vecs[2] = '{data: 16'hF0E9, dp: 4'b0010, mask: 4'b1010,
                exp_hex: 16'hF0E9, exp_dp: 4'b0010, exp_an: 16'h7FDF};

    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = 16'h0000;
    bus.dp_in   = 4'h0;
    bus.mask_in = 4'h0;
    repeat (3) @(negedge clk);

    chk("rst_an", {28'd0, bus.an}, 32'hF);
    chk("rst_hex", {28'd0, bus.hex_out}, 32'h0);
    chk("rst_dp", {31'd0, bus.dp_out}, 32'd0);
    chk("rst_ack", {31'd0, bus.load_ack}, 32'd0);
    chk("rst_pending", {31'd0, bus.pending}, 32'd0);
    chk("rst_ft", {31'd0, bus.frame_tick}, 32'd0);

    // Two frames with nothing committed: dark display, frame_tick every 32 cycles.
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    for (int s = 1; s <= 64; s++) begin
      @(negedge clk);
      chk($sformatf("dark_an_s%0d", s), {28'd0, bus.an}, 32'hF);
      chk($sformatf("dark_ft_s%0d", s), {31'd0, bus.frame_tick}, (s % 32 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("dark_ack_s%0d", s), {31'd0, bus.load_ack}, 32'd0);
    end

    for (int i = 0; i < 3; i++) begin
      do_load(vecs[i].data, vecs[i].dp, vecs[i].mask);
      chk($sformatf("vec%0d_pending", i), {31'd0, bus.pending}, 32'd1);
      wait_ack($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_pending_clr", i), {31'd0, bus.pending}, 32'd0);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_hex, vecs[i].exp_dp, vecs[i].exp_an,
                  1'b1, 1'b1);
    end

    // Two loads within one frame: last one wins, one acknowledge.
    repeat (5) @(negedge clk);
    do_load(16'h1111, 4'h0, 4'hF);
    repeat (2) @(negedge clk);
    do_load(16'h2222, 4'h0, 4'hF);
    wait_ack("dbl");
    check_frame("dbl_f1", 16'h2222, 4'h0, 16'h7BDE, 1'b1, 1'b1);
    check_frame("dbl_f2", 16'h2222, 4'h0, 16'h7BDE, 1'b1, 1'b0);

    // Load coincident with the wrap cycle: X commits now, Y stays pending.
    do_load(16'h5A5A, 4'h0, 4'hF);
    repeat (30) @(negedge clk);
    do_load(16'h0BCD, 4'b0001, 4'hF);
    chk("coinc_ack", {31'd0, bus.load_ack}, 32'd1);
    chk("coinc_pending", {31'd0, bus.pending}, 32'd1);
    check_frame("coinc_x", 16'h5A5A, 4'h0, 16'h7BDE, 1'b1, 1'b1);
    check_frame("coinc_y", 16'h0BCD, 4'b0001, 16'h7BDE, 1'b1, 1'b1);

    // Enable dropped mid-frame: blank at once, loads queue, restart at digit 0.
    repeat (11) @(negedge clk);
    chk("en_pre_an", {28'd0, bus.an}, 32'hD);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_off_an", {28'd0, bus.an}, 32'hF);
    chk("en_off_hex", {28'd0, bus.hex_out}, 32'hD);
    chk("en_off_dp", {31'd0, bus.dp_out}, 32'd1);
    do_load(16'h9C0E, 4'b1000, 4'b0111);
    chk("en_off_pending", {31'd0, bus.pending}, 32'd1);
    for (int s = 0; s < 40; s++) begin
      chk($sformatf("en_off_an_s%0d", s), {28'd0, bus.an}, 32'hF);
      chk($sformatf("en_off_ack_s%0d", s), {31'd0, bus.load_ack}, 32'd0);
      @(negedge clk);
    end
    chk("en_off_pending_held", {31'd0, bus.pending}, 32'd1);
    bus.enable = 1'b1;
    check_frame("en_resume_y", 16'h0BCD, 4'b0001, 16'h7BDE, 1'b0, 1'b0);
    check_frame("en_resume_z", 16'h9C0E, 4'b1000, 16'hFBDE, 1'b1, 1'b1);

    // Reset asserted in the middle of a DRIVE window.
    repeat (3) @(negedge clk);
    chk("rst_mid_pre_an", {28'd0, bus.an}, 32'hE);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_an", {28'd0, bus.an}, 32'hF);
    chk("rst_mid_hex", {28'd0, bus.hex_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      @(negedge clk);
      chk($sformatf("post_rst_an_s%0d", s), {28'd0, bus.an}, 32'hF);
      chk($sformatf("post_rst_hex_s%0d", s), {28'd0, bus.hex_out}, 32'h0);
      chk($sformatf("post_rst_ack_s%0d", s), {31'd0, bus.load_ack}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
